// File: rtl/cam_serializer_pkg.sv
// cam_serializer_pkg: shared state type and elaboration helpers for the CAM stream serializer
package cam_serializer_pkg;
  typedef enum logic [1:0] {IDLE, ACTIVE, GAP} state_t;
  function automatic int beats(input int data_width, input int bus_width);
    return data_width / bus_width;
  endfunction
  function automatic bit bus_width_ok(input int bus_width);
    return bus_width == 1 || bus_width == 2 || bus_width == 4 || bus_width == 8 || bus_width == 16;
  endfunction
endpackage

// File: rtl/sync_word_fifo.sv
// sync_word_fifo: word FIFO with registered full, empty and level flags
module sync_word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [WIDTH-1:0]       wdata,
  input  logic                   pop,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  logic [AW:0] level_next;
  always_comb begin
    do_push = push && !full;
    do_pop = pop && !empty;
    level_next = level + (AW+1)'(do_push) - (AW+1)'(do_pop);
  end
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk_i)
    if (do_push) mem[wr_ptr] <= wdata;
  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      wr_ptr <= do_push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= do_pop ? rd_ptr + AW'(1) : rd_ptr;
      level <= level_next;
      full <= level_next == (AW+1)'(DEPTH);
      empty <= level_next == '0;
    end
endmodule

// File: rtl/cam_stream_serializer.sv
// cam_stream_serializer: FIFO-buffered word serializer driving an ESP32 LCD_CAM style
// parallel bus with divided pixel clock and frame sync; back-to-back words share one frame.
module cam_stream_serializer
  import cam_serializer_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int BUS_WIDTH   = 4,
  parameter int COUNT_WIDTH = 4,
  parameter int FIFO_DEPTH  = 8,
  parameter int MAX_BURST   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst_n,
  input  logic                        wr_i,
  input  logic [DATA_WIDTH-1:0]       data_i,
  output logic                        full_o,
  output logic [$clog2(FIFO_DEPTH):0] level_o,
  output logic                        overflow_o,
  output logic                        cam_pclk,
  output logic                        cam_sync,
  output logic [BUS_WIDTH-1:0]        cam_data,
  output logic                        busy
);
  localparam int BEATS  = beats(DATA_WIDTH, BUS_WIDTH);
  localparam int BEAT_W = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int WORD_W = $clog2(MAX_BURST + 1);

  if (DATA_WIDTH % BUS_WIDTH != 0) begin : g_bad_ratio
    $error("DATA_WIDTH must be a multiple of BUS_WIDTH");
  end
  if (!bus_width_ok(BUS_WIDTH)) begin : g_bad_bus
    $error("BUS_WIDTH must be 1, 2, 4, 8 or 16");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two, at least 2");
  end
  if (COUNT_WIDTH < 1 || MAX_BURST < 1) begin : g_bad_misc
    $error("COUNT_WIDTH and MAX_BURST must be at least 1");
  end

  state_t state;
  logic [COUNT_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] rdata, shreg;
  logic [BEAT_W-1:0] beat;
  logic [WORD_W-1:0] words;
  logic fall_tick, empty, pop, last_beat, more;

  // Everything on the bus moves at the counter wrap, which is also the PCLK falling edge.
  always_comb begin
    fall_tick = &cnt;
    last_beat = beat == BEAT_W'(BEATS - 1);
    more = !empty && words < WORD_W'(MAX_BURST);
    pop = fall_tick && ((state == IDLE && !empty) || (state == ACTIVE && last_beat && more));
    busy = state != IDLE || !empty;
  end
  assign cam_pclk = cnt[COUNT_WIDTH-1];

  sync_word_fifo #(.WIDTH(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i (clk_i),
    .rst_n (rst_n),
    .push  (wr_i),
    .wdata (data_i),
    .pop   (pop),
    .rdata (rdata),
    .full  (full_o),
    .empty (empty),
    .level (level_o)
  );

  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      cnt <= '0;
      overflow_o <= 1'b0;
    end else begin
      cnt <= cnt + COUNT_WIDTH'(1);
      overflow_o <= wr_i && full_o;
    end

  always_ff @(posedge clk_i or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      shreg <= '0;
      beat <= '0;
      words <= '0;
      cam_sync <= 1'b0;
      cam_data <= '0;
    end else if (fall_tick) begin
      case (state)
        IDLE:
          if (pop) begin
            shreg <= rdata >> BUS_WIDTH;
            cam_data <= rdata[BUS_WIDTH-1:0];
            cam_sync <= 1'b1;
            beat <= '0;
            words <= WORD_W'(1);
            state <= ACTIVE;
          end
        ACTIVE:
          if (!last_beat) begin
            cam_data <= shreg[BUS_WIDTH-1:0];
            shreg <= shreg >> BUS_WIDTH;
            beat <= beat + BEAT_W'(1);
          end else if (pop) begin
            shreg <= rdata >> BUS_WIDTH;
            cam_data <= rdata[BUS_WIDTH-1:0];
            beat <= '0;
            words <= words + WORD_W'(1);
          end else begin
            cam_sync <= 1'b0;
            cam_data <= '0;
            state <= GAP;
          end
        GAP: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_cam_stream_serializer.sv
// tb_cam_stream_serializer: checks a default instance and a narrow-burst, byte-wide, fast-PCLK
// instance by rebuilding words and frames from the pins alone.
module tb_cam_stream_serializer;
  logic clk, rst_n, clr;
  logic a_wr, a_full, a_ovf, a_pclk, a_sync, a_busy;
  logic [31:0] a_din;
  logic [3:0] a_level, a_data;
  logic b_wr, b_full, b_ovf, b_pclk, b_sync, b_busy;
  logic [31:0] b_din;
  logic [2:0] b_level;
  logic [7:0] b_data;
  int checks, errors;

  typedef struct {
    logic [31:0] word;
    logic [31:0] seq_a;
    logic [31:0] seq_b;
  } vec_t;
  vec_t vecs[5];

  cam_stream_serializer u_a (
    .clk_i(clk), .rst_n(rst_n), .wr_i(a_wr), .data_i(a_din), .full_o(a_full), .level_o(a_level),
    .overflow_o(a_ovf), .cam_pclk(a_pclk), .cam_sync(a_sync), .cam_data(a_data), .busy(a_busy)
  );
  cam_stream_serializer #(.DATA_WIDTH(32), .BUS_WIDTH(8), .COUNT_WIDTH(2), .FIFO_DEPTH(4), .MAX_BURST(2)) u_b (
    .clk_i(clk), .rst_n(rst_n), .wr_i(b_wr), .data_i(b_din), .full_o(b_full), .level_o(b_level),
    .overflow_o(b_ovf), .cam_pclk(b_pclk), .cam_sync(b_sync), .cam_data(b_data), .busy(b_busy)
  );

  initial clk = 0;
  always #5 clk = ~clk;
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  // Pin-level monitors: beats are taken on PCLK rising edges while sync is high.
  logic [31:0] a_acc, a_seq, b_acc, b_seq;
  logic a_pclk_q, a_sync_q, b_pclk_q, b_sync_q, b_seen;
  int a_nb, a_hi, a_ovf_n, a_lvl_max, a_bad, b_nb, b_hi, b_lo, b_bad;
  logic [31:0] a_words[$], a_seqs[$], b_words[$], b_seqs[$];
  int a_fbeats[$], a_fclk[$], b_fbeats[$], b_fclk[$], b_gaps[$];

  always @(negedge clk) begin
    if (clr) begin
      a_words.delete(); a_seqs.delete(); a_fbeats.delete(); a_fclk.delete();
      a_nb = 0; a_hi = 0; a_ovf_n = 0; a_lvl_max = 0; a_acc = '0; a_seq = '0;
    end else begin
      if (a_pclk && !a_pclk_q && a_sync) begin
        a_acc = {a_data, a_acc[31:4]};
        a_seq = {a_seq[27:0], a_data};
        a_nb++;
        if (a_nb % 8 == 0) a_words.push_back(a_acc);
      end
      if (a_sync) a_hi++;
      if (!a_sync && a_sync_q) begin
        a_fbeats.push_back(a_nb); a_fclk.push_back(a_hi); a_seqs.push_back(a_seq);
        a_nb = 0; a_hi = 0;
      end
      if (!a_sync && a_data != 0) a_bad++;
      if (a_ovf) a_ovf_n++;
      if (int'(a_level) > a_lvl_max) a_lvl_max = int'(a_level);
    end
    a_pclk_q = a_pclk;
    a_sync_q = a_sync;
  end

  always @(negedge clk) begin
    if (clr) begin
      b_words.delete(); b_seqs.delete(); b_fbeats.delete(); b_fclk.delete(); b_gaps.delete();
      b_nb = 0; b_hi = 0; b_lo = 0; b_seen = 0; b_acc = '0; b_seq = '0;
    end else begin
      if (b_pclk && !b_pclk_q && b_sync) begin
        b_acc = {b_data, b_acc[31:8]};
        b_seq = {b_seq[23:0], b_data};
        b_nb++;
        if (b_nb % 4 == 0) b_words.push_back(b_acc);
      end
      if (b_sync && !b_sync_q && b_seen) b_gaps.push_back(b_lo);
      if (b_sync) b_hi++;
      if (!b_sync && b_sync_q) begin
        b_fbeats.push_back(b_nb); b_fclk.push_back(b_hi); b_seqs.push_back(b_seq);
        b_nb = 0; b_hi = 0; b_lo = 0; b_seen = 1;
      end
      if (!b_sync) b_lo++;
      if (!b_sync && b_data != 0) b_bad++;
    end
    b_pclk_q = b_pclk;
    b_sync_q = b_sync;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear();
    clr = 1;
    repeat (2) @(negedge clk);
    clr = 0;
  endtask

  task automatic reset_dut();
    rst_n = 0;
    clr = 1;
    repeat (2) @(negedge clk);
    clr = 0;
    rst_n = 1;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((a_busy || b_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", n < budget, 1);
  endtask

  task automatic write_a(input logic [31:0] w);
    a_din = w; a_wr = 1;
    @(negedge clk);
    a_wr = 0;
  endtask

  task automatic write_b(input logic [31:0] w);
    b_din = w; b_wr = 1;
    @(negedge clk);
    b_wr = 0;
  endtask

  logic [31:0] exp_q[$];
  logic [31:0] w;
  int n, m;

  initial begin
    vecs[0] = '{32'h12345678, 32'h87654321, 32'h78563412};
    vecs[1] = '{32'hA5C30F1E, 32'hE1F03C5A, 32'h1E0FC3A5};
    vecs[2] = '{32'h00000000, 32'h00000000, 32'h00000000};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF};
    vecs[4] = '{32'h0F1E2D3C, 32'hC3D2E1F0, 32'h3C2D1E0F};
    checks = 0; errors = 0;
    a_wr = 0; b_wr = 0; a_din = '0; b_din = '0; clr = 0; rst_n = 0;
    repeat (3) @(negedge clk);
    chk("rst_a_outputs", {a_pclk, a_sync, a_data, a_busy, a_full, a_ovf, a_level}, '0);
    chk("rst_b_outputs", {b_pclk, b_sync, b_data, b_busy, b_full, b_ovf, b_level}, '0);
    reset_dut();

    // Single-word frames on both instances.
    for (int i = 0; i < 5; i++) begin
      clear();
      a_din = vecs[i].word; b_din = vecs[i].word; a_wr = 1; b_wr = 1;
      @(negedge clk);
      a_wr = 0; b_wr = 0;
      chk("busy_after_write", {a_busy, b_busy}, 2'b11);
      wait_idle(2000);
      chk("a_frame_count", a_seqs.size(), 1);
      chk("b_frame_count", b_seqs.size(), 1);
      if (a_seqs.size() == 1) begin
        chk("a_beat_sequence", a_seqs[0], vecs[i].seq_a);
        chk("a_frame_beats", a_fbeats[0], 8);
        chk("a_sync_clk", a_fclk[0], 128);
        chk("a_word", a_words[0], vecs[i].word);
      end
      if (b_seqs.size() == 1) begin
        chk("b_beat_sequence", b_seqs[0], vecs[i].seq_b);
        chk("b_frame_beats", b_fbeats[0], 4);
        chk("b_sync_clk", b_fclk[0], 16);
      end
    end

    // Three back-to-back words stream as one 24-beat frame.
    reset_dut();
    write_a(32'h11111111);
    write_a(32'h22222222);
    write_a(32'h33333333);
    wait_idle(3000);
    chk("burst_level_peak", a_lvl_max, 3);
    chk("burst_frame_count", a_fbeats.size(), 1);
    if (a_fbeats.size() == 1) begin
      chk("burst_frame_beats", a_fbeats[0], 24);
      chk("burst_sync_clk", a_fclk[0], 384);
    end
    chk("burst_word_count", a_words.size(), 3);
    for (int k = 0; k < 3 && k < a_words.size(); k++)
      chk("burst_word", a_words[k], {8{4'(k + 1)}});

    // Nine writes before the first fall tick: the ninth is dropped.
    reset_dut();
    for (int i = 0; i < 9; i++) begin
      a_din = 32'hC0DE0000 + i; a_wr = 1;
      @(negedge clk);
      if (i == 6) chk("not_full_at_7", a_full, 0);
      if (i == 7) begin
        chk("full_at_8", a_full, 1);
        chk("level_at_8", a_level, 8);
      end
    end
    a_wr = 0;
    repeat (3) @(negedge clk);
    chk("level_after_drop", a_level, 8);
    wait_idle(3000);
    chk("overflow_cycles", a_ovf_n, 1);
    chk("ovf_frame_count", a_fbeats.size(), 1);
    if (a_fbeats.size() == 1) chk("ovf_frame_beats", a_fbeats[0], 64);
    chk("ovf_word_count", a_words.size(), 8);
    for (int k = 0; k < 8 && k < a_words.size(); k++)
      chk("ovf_word", a_words[k], 32'hC0DE0000 + k);

    // Reset during the third beat of a frame.
    clear();
    write_a(32'hABCDEF01);
    n = 0;
    while (a_nb < 3 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("reached_beat3", n < 1000, 1);
    #2 rst_n = 0;
    #1;
    chk("midreset_outputs", {a_sync, a_pclk, a_data, a_busy, a_level}, '0);
    clr = 1;
    repeat (2) @(negedge clk);
    clr = 0; rst_n = 1;
    write_a(32'h00000000);
    wait_idle(2000);
    chk("post_reset_frames", a_seqs.size(), 1);
    if (a_seqs.size() == 1) begin
      chk("post_reset_beats", a_fbeats[0], 8);
      chk("post_reset_seq", a_seqs[0], 0);
    end

    // Burst limit of two on the fast instance: 8 beats, a gap, then 4 beats.
    clear();
    write_b(32'hAAAA0001);
    write_b(32'hBBBB0002);
    write_b(32'hCCCC0003);
    wait_idle(500);
    chk("maxb_frame_count", b_fbeats.size(), 2);
    if (b_fbeats.size() == 2) begin
      chk("maxb_first_beats", b_fbeats[0], 8);
      chk("maxb_second_beats", b_fbeats[1], 4);
    end
    chk("maxb_gap_count", b_gaps.size(), 1);
    if (b_gaps.size() == 1) chk("maxb_gap_len", b_gaps[0] >= 4, 1);
    chk("maxb_word_count", b_words.size(), 3);
    if (b_words.size() == 3) chk("maxb_order", {b_words[0], b_words[1], b_words[2]},
      {32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003} );

    // Random word groups: order kept, frames whole words, at most two per frame.
    for (int r = 0; r < 20; r++) begin
      clear();
      exp_q.delete();
      n = $urandom_range(1, 4);
      for (int k = 0; k < n; k++) begin
        w = $urandom;
        exp_q.push_back(w);
        write_b(w);
        m = $urandom_range(0, 5);
        repeat (m) @(negedge clk);
      end
      wait_idle(500);
      chk("rnd_word_count", b_words.size(), n);
      for (int k = 0; k < n && k < b_words.size(); k++)
        chk("rnd_word", b_words[k], exp_q[k]);
      foreach (b_fbeats[k])
        chk("rnd_frame_shape", b_fbeats[k] % 4 == 0 && b_fbeats[k] >= 4 && b_fbeats[k] <= 8, 1);
      foreach (b_gaps[k])
        chk("rnd_gap_len", b_gaps[k] >= 4, 1);
    end

    chk("data_zero_when_sync_low", a_bad + b_bad, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
